// File: rtl/timer_periph_if.sv
// Data-bus connection between the MIPS datapath and the timer peripheral.
// The master drives the strobes, address and store data; the slave returns load data.
interface timer_periph_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, output wr, output addr, output wdata, input rdata);
  modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/timer_periph.sv
// Memory-mapped timer: reload register, prescaled up-counter, free-running
// cycle counter and a level interrupt that software clears through TCON.
module timer_periph #(
  parameter logic [31:0] BASE = 32'h4000_0000
) (
  input  logic           clk,
  input  logic           reset,
  timer_periph_if.slave  bus,
  output logic           irqout
);

  localparam logic [2:0] OFF_TH   = 3'd0;
  localparam logic [2:0] OFF_TL   = 3'd1;
  localparam logic [2:0] OFF_TCON = 3'd2;
  localparam logic [2:0] OFF_PRE  = 3'd3;
  localparam logic [2:0] OFF_SYS  = 3'd5;

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;      // {IS, IE, EN}
  logic [15:0] pre_q, pre_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic [31:0] systick_q, systick_d;

  logic       hit;
  logic [2:0] off;
  logic       wr_th, wr_tl, wr_tcon, wr_pre;
  logic       tick, tl_max, ovf;
  logic       unused_addr_bits;

  // Byte-lane bits carry no meaning for word registers.
  assign unused_addr_bits = ^bus.addr[1:0];

  assign hit     = (bus.addr[31:5] == BASE[31:5]);
  assign off     = bus.addr[4:2];
  assign wr_th   = bus.wr & hit & (off == OFF_TH);
  assign wr_tl   = bus.wr & hit & (off == OFF_TL);
  assign wr_tcon = bus.wr & hit & (off == OFF_TCON);
  assign wr_pre  = bus.wr & hit & (off == OFF_PRE);

  // tick/overflow come from registered state only; a TL write on the same
  // edge suppresses the increment/reload and therefore the overflow too.
  assign tick   = tcon_q[0] & (pcnt_q == pre_q);
  assign tl_max = (tl_q == 32'hFFFF_FFFF);
  assign ovf    = tick & tl_max & ~wr_tl;

  // Interrupt depends on registers only, never on bus inputs.
  assign irqout = tcon_q[1] & tcon_q[2];

  // Next-state: prescaler, counter/reload, software writes, hardware IS set.
  always_comb begin
    th_d      = th_q;
    tl_d      = tl_q;
    tcon_d    = tcon_q;
    pre_d     = pre_q;
    pcnt_d    = pcnt_q;
    systick_d = systick_q + 32'd1;

    if (!tcon_q[0] || tick) pcnt_d = '0;
    else                    pcnt_d = pcnt_q + 16'd1;

    if (wr_pre) begin
      pre_d  = bus.wdata[15:0];
      pcnt_d = '0;
    end

    if (wr_th) th_d = bus.wdata;

    if (wr_tl)     tl_d = bus.wdata;
    else if (tick) tl_d = tl_max ? th_q : tl_q + 32'd1;

    if (wr_tcon) tcon_d = bus.wdata[2:0];
    // Hardware set beats a simultaneous software clear so no interrupt is lost.
    if (ovf && tcon_q[1]) tcon_d[2] = 1'b1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= '0;
      pre_q     <= '0;
      pcnt_q    <= '0;
      systick_q <= '0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      pre_q     <= pre_d;
      pcnt_q    <= pcnt_d;
      systick_q <= systick_d;
    end
  end

  // Combinational load data; zero when not selected or on unmapped offsets.
  always_comb begin
    bus.rdata = '0;
    if (bus.rd && hit) begin
      case (off)
        OFF_TH:   bus.rdata = th_q;
        OFF_TL:   bus.rdata = tl_q;
        OFF_TCON: bus.rdata = {29'd0, tcon_q};
        OFF_PRE:  bus.rdata = {16'd0, pre_q};
        OFF_SYS:  bus.rdata = systick_q;
        default:  bus.rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_periph.sv
// Self-checking bench for timer_periph: directed scenarios followed by random
// bus traffic, all compared against a behavioural model of the register map.
module tb_timer_periph;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic clk = 1'b0;
  logic reset;
  logic irqout;

  timer_periph_if bus_if ();

  timer_periph #(.BASE(BASE)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus_if),
    .irqout (irqout)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: ticks are scheduled as absolute edge numbers and the
  // counter overflow is the carry out of a 33-bit increment.
  logic [31:0] m_th, m_tl, m_sys;
  logic [15:0] m_pre;
  logic        m_en, m_ie, m_is;
  longint      m_edge = 0;
  longint      m_next = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input int o);
    return BASE + 32'(o * 4);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:5] != BASE[31:5]) return 32'd0;
    case (a[4:2])
      3'd0: return m_th;
      3'd1: return m_tl;
      3'd2: return {29'd0, m_is, m_ie, m_en};
      3'd3: return {16'd0, m_pre};
      3'd5: return m_sys;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_th = 0; m_tl = 0; m_sys = 0; m_pre = 0;
    m_en = 0; m_ie = 0; m_is = 0;
  endtask

  // Apply one clock edge to the model, with an optional bus write.
  task automatic m_step(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic        hit, tick, ovf, wtl;
    logic [32:0] sum;
    logic [2:0]  o;
    logic [31:0] old_th;
    logic [15:0] old_pre;
    logic        old_en, old_ie;
    hit = (a[31:5] == BASE[31:5]);
    o = a[4:2];
    old_th = m_th; old_pre = m_pre; old_en = m_en; old_ie = m_ie;
    tick = m_en && (m_edge == m_next);
    sum  = {1'b0, m_tl} + 33'd1;
    wtl  = w && hit && (o == 3'd1);
    ovf  = tick && sum[32] && !wtl;
    if (tick) m_next = m_edge + longint'(old_pre) + 1;
    if (wtl)       m_tl = d;
    else if (tick) m_tl = sum[32] ? old_th : sum[31:0];
    if (w && hit && o == 3'd0) m_th = d;
    if (w && hit && o == 3'd3) begin
      m_pre  = d[15:0];
      m_next = m_edge + longint'(d[15:0]) + 1;
    end
    if (w && hit && o == 3'd2) begin
      if (!old_en && d[0]) m_next = m_edge + longint'(old_pre) + 1;
      m_en = d[0]; m_ie = d[1]; m_is = d[2];
    end
    if (ovf && old_ie) m_is = 1'b1;
    m_sys = m_sys + 32'd1;
    m_edge++;
  endtask

  task automatic rd_reg(input logic [31:0] a, output logic [31:0] v);
    bus_if.rd = 1'b1; bus_if.addr = a;
    #1 v = bus_if.rdata;
    bus_if.rd = 1'b0; bus_if.addr = '0;
  endtask

  // One bus cycle; with r set, the load data seen before the edge is checked.
  task automatic cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic r, input string tag);
    bus_if.wr = w; bus_if.rd = r; bus_if.addr = a; bus_if.wdata = d;
    if (r) begin
      #1 chk({tag, "_rdpre"}, bus_if.rdata, m_read(a));
    end
    @(posedge clk);
    m_step(w, a, d);
    #1;
    bus_if.wr = 1'b0; bus_if.rd = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
    if (w) $display("[%0t] %s: wr addr=%h data=%h rd=%0d", $time, tag, a, d, r);
  endtask

  task automatic wr_off(input int o, input logic [31:0] d, input string tag);
    cycle(1'b1, addr_of(o), d, 1'b0, tag);
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, 1'b0, "idle");
  endtask

  task automatic check_all(input string tag);
    logic [31:0] v;
    for (int o = 0; o < 8; o++) begin
      rd_reg(addr_of(o), v);
      chk($sformatf("%s_off%0d", tag, o), v, m_read(addr_of(o)));
    end
    chk({tag, "_irq"}, {31'd0, irqout}, {31'd0, m_is & m_ie});
  endtask

  task automatic chk_reg(input string tag, input int o, input logic [31:0] exp);
    logic [31:0] v;
    rd_reg(addr_of(o), v);
    chk(tag, v, exp);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
    m_reset();
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] a, d;
    logic        w, r;
    int unsigned sel, o;

    bus_if.rd = 1'b0; bus_if.wr = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
    m_reset();

    // Reset state
    do_reset(2);
    check_all("rst");
    chk_reg("rst_sys0", 5, 32'd0);
    chk("rst_irq", {31'd0, irqout}, 32'd0);
    idle();
    chk_reg("rst_sys1", 5, 32'd1);

    // Reload period with PRE=0
    wr_off(0, 32'hFFFF_FFFD, "th");
    wr_off(1, 32'hFFFF_FFFD, "tl");
    wr_off(3, 32'd0, "pre");
    wr_off(2, 32'd3, "tcon");
    idle(); chk_reg("rl_tl1", 1, 32'hFFFF_FFFE);
    idle(); chk_reg("rl_tl2", 1, 32'hFFFF_FFFF);
    chk("rl_irq_pre", {31'd0, irqout}, 32'd0);
    idle(); chk_reg("rl_tl3", 1, 32'hFFFF_FFFD);
    chk_reg("rl_tcon", 2, 32'd7);
    chk("rl_irq", {31'd0, irqout}, 32'd1);
    repeat (3) idle();
    chk_reg("rl_period", 1, 32'hFFFF_FFFD);
    check_all("rl");

    // Clear, then clear colliding with overflow
    wr_off(2, 32'd3, "clr");
    chk("clr_irq", {31'd0, irqout}, 32'd0);
    chk_reg("clr_tcon", 2, 32'd3);
    idle();
    chk_reg("clr_tl", 1, 32'hFFFF_FFFF);
    wr_off(2, 32'd3, "coll");
    chk_reg("coll_tcon", 2, 32'd7);
    chk("coll_irq", {31'd0, irqout}, 32'd1);
    chk_reg("coll_tl", 1, 32'hFFFF_FFFD);

    // Prescaler PRE=2
    wr_off(2, 32'd0, "tcon");
    wr_off(3, 32'd2, "pre");
    wr_off(1, 32'd0, "tl");
    wr_off(2, 32'd1, "tcon");
    for (int k = 1; k <= 7; k++) begin
      idle();
      chk_reg($sformatf("pre_k%0d", k), 1, 32'(k / 3));
    end
    wr_off(3, 32'd2, "pre_restart");
    idle(); chk_reg("pre_rs1", 1, 32'd2);
    idle(); chk_reg("pre_rs2", 1, 32'd2);
    idle(); chk_reg("pre_rs3", 1, 32'd3);
    check_all("pre");

    // Masked overflow, then software trigger
    wr_off(2, 32'd0, "tcon");
    wr_off(0, 32'd5, "th");
    wr_off(1, 32'hFFFF_FFFE, "tl");
    wr_off(3, 32'd0, "pre");
    wr_off(2, 32'd1, "tcon");
    idle(); chk_reg("mask_tl1", 1, 32'hFFFF_FFFF);
    idle(); chk_reg("mask_tl2", 1, 32'd5);
    chk_reg("mask_tcon", 2, 32'd1);
    chk("mask_irq", {31'd0, irqout}, 32'd0);
    wr_off(2, 32'd7, "swtrig");
    chk_reg("sw_tcon", 2, 32'd7);
    chk("sw_irq", {31'd0, irqout}, 32'd1);

    // Decode: ignored writes, unmapped reads, rd low, rd+wr together
    wr_off(5, 32'd0, "sys_wr");
    cycle(1'b1, 32'h4000_0020, 32'h0000_1234, 1'b0, "oor_wr");
    chk_reg("dec_th", 0, 32'd5);
    check_all("dec");
    bus_if.rd = 1'b0; bus_if.addr = addr_of(0);
    #1 chk("rd_low", bus_if.rdata, 32'd0);
    bus_if.addr = '0;
    cycle(1'b1, addr_of(1), 32'h0000_AAAA, 1'b1, "rdwr");
    chk_reg("rdwr_tl", 1, 32'h0000_AAAA);

    // Random traffic against the model
    wr_off(0, 32'hFFFF_FFF0, "th");
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      o   = $urandom_range(0, 7);
      w   = (sel < 6);
      a   = addr_of(int'(o));
      if (sel == 5) a = 32'h5000_0000 | (o << 2);
      d = $urandom;
      if (o == 3) d = $urandom_range(0, 3);
      if (o == 1 && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFFF - $urandom_range(0, 6);
      if (o == 0) d = 32'hFFFF_FFFF - $urandom_range(0, 12);
      r = 1'($urandom_range(0, 1));
      cycle(w, a, d, r, "rnd");
      check_all("rnd");
    end

    // Reset mid-count
    wr_off(2, 32'd3, "tcon");
    idle();
    do_reset(1);
    check_all("midrst");
    chk("midrst_irq", {31'd0, irqout}, 32'd0);
    chk_reg("midrst_tl", 1, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
